result_serializer: RTL and testbench
====================================

Name: result_serializer

Overview:
- Sits between Calculator10 and uart_tx, downstream of the multiplier and upstream of the transmitter.
- Captures the flat 10x10 product vector when multiplication completes.
- Streams only the active NxN elements, row-major, as bytes to uart_tx using its start/busy handshake.
- Replaces ad-hoc result_index byte slicing in the top level; guarantees one byte per UART frame and exact byte count.

Parameters:
MAX_N, 10, maximum matrix dimension
ELEM_W, 16, bits per result element (multiple of 8)
BYTES_PER_ELEM, ELEM_W/8, derived; bytes sent per element

Ports:
clk  in  1  bclk domain clock
rst  in  1  asynchronous reset, active-low
load  in  1  one-cycle pulse (mult_done); snapshot result and start streaming
matrix_size  in  4  active dimension N, sampled on load
result  in  MAX_N*MAX_N*ELEM_W  flat product; element (r,c) at [(r*MAX_N+c)*ELEM_W +: ELEM_W]
tx_busy  in  1  uart_tx busy
tx_start  out  1  one-cycle start pulse to uart_tx
tx_data  out  8  byte to uart_tx, stable from tx_start until next tx_start
busy  out  1  high from accepted load until done
done  out  1  one-cycle pulse after last byte's frame completes

Behaviour:
- Reset (rst=0, async): state IDLE; tx_start=0, tx_data=0, busy=0, done=0; row/col/byte counters=0; snapshot register cleared.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_FREE, FINISH.
- IDLE:
  - load=1 and matrix_size==0 -> FINISH, sending no bytes.
  - load=1 otherwise -> capture result into snapshot, n_reg=min(matrix_size, MAX_N), row=col=byte=0, busy=1, -> ISSUE.
- ISSUE:
  - Wait until tx_busy=0.
  - Then drive tx_data=selected byte and tx_start=1 for exactly one cycle -> WAIT_ACK.
  - First tx_start occurs on the 2nd clk after load if tx_busy=0 (load at cycle 0, ISSUE at 1, tx_start registered high during cycle 2).
- WAIT_ACK: wait for tx_busy=1 -> WAIT_FREE. tx_start stays 0; a start is never re-issued.
- WAIT_FREE: wait for tx_busy=0, then advance:
  - byte<BYTES_PER_ELEM-1 -> byte+1.
  - else byte=0 and col+1.
  - col==n_reg-1 -> col=0, row+1.
  - last byte of (n_reg-1, n_reg-1) -> FINISH; otherwise -> ISSUE.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Byte order: most-significant byte of each element first. Elements are row-major over r,c < n_reg only; padding elements are never sent.
- Total bytes = n_reg*n_reg*BYTES_PER_ELEM (N=10 -> 200).
- Snapshot isolates output from changes on result after load.
- load while busy=1 (including FINISH): ignored; no restart, no effect on counters.
- load and done in the same cycle: load ignored.
- matrix_size > MAX_N: clamped to MAX_N.
- tx_busy already high at load: ISSUE holds until it drops.
- Reset mid-stream: immediate abort, outputs to reset values, no done pulse.
- Counter widths: row/col 4 bits, byte index clog2(BYTES_PER_ELEM) (min 1).

Decomposition:
- Shared package (matmul_pkg) holds:
  - MAX_N, ELEM_W.
  - State encoding localparams for IDLE/ISSUE/WAIT_ACK/WAIT_FREE/FINISH.
  - Element-index helper constant MAX_ELEMS = MAX_N*MAX_N.
- One sub-module is natural: result_byte_sel, a combinational mux (snapshot, row, col, byte -> 8-bit byte). The FSM and counters stay in result_serializer.

Test Plan:
- N=2, elements (0,0)=0x1234, (0,1)=0x0005, (1,0)=0xABCD, (1,1)=0x00FF; uart model with busy 1 cycle after start for 10 cycles -> bytes 12 34 00 05 AB CD 00 FF, then done pulse, busy=0.
- matrix_size=0 with load -> no tx_start ever, done one cycle after load, busy never observed beyond that.
- matrix_size=10, result element k = k*257 -> exactly 200 bytes, byte 2k = k, byte 2k+1 = k; done once.
- matrix_size=12 -> clamped; exactly 200 bytes, same order as N=10.
- Second load pulse and a result change mid-stream (N=3) -> ignored; 18 bytes reflect the first snapshot only.
- Assert rst=0 after 5th byte's tx_start (N=3) -> tx_start/busy/done drop asynchronously. A new load then restarts from element (0,0) high byte.
- tx_busy held high for 3 cycles before load -> first tx_start delayed until the cycle after tx_busy falls; no byte lost or duplicated.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the result streaming path.
// Sizes: MAX_N x MAX_N elements of ELEM_W bits, sent MSB byte first.
package matmul_pkg;

    localparam int MAX_N          = 10;
    localparam int ELEM_W         = 16;
    localparam int BYTES_PER_ELEM = ELEM_W / 8;
    localparam int MAX_ELEMS      = MAX_N * MAX_N;
    localparam int RESULT_W       = MAX_ELEMS * ELEM_W;
    localparam int BYTE_IDX_W     =
        (BYTES_PER_ELEM > 1) ? $clog2(BYTES_PER_ELEM) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_FREE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

endpackage

// File: rtl/result_serializer_if.sv
// Byte link towards uart_tx: start/data from the serializer, busy back.
// master = serializer side, slave = transmitter side.
interface result_serializer_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy
    );

endinterface

// File: rtl/result_byte_sel.sv
// Picks one byte of element (row, col) from the snapshot, MSB byte first.
// snap_i/row_i/col_i/byte_i in, byte_o out; purely combinational.
module result_byte_sel
    import matmul_pkg::*;
(
    input  logic [RESULT_W-1:0]   snap_i,
    input  logic [3:0]            row_i,
    input  logic [3:0]            col_i,
    input  logic [BYTE_IDX_W-1:0] byte_i,
    output logic [7:0]            byte_o
);

    int unsigned       idx;
    int unsigned       shamt;
    logic [ELEM_W-1:0] elem;

    always_comb begin
        idx    = 32'(row_i) * 32'(MAX_N) + 32'(col_i);
        elem   = snap_i[idx*ELEM_W +: ELEM_W];
        // byte 0 is the most-significant byte of the element
        shamt  = 8 * (32'(BYTES_PER_ELEM) - 1 - 32'(byte_i));
        byte_o = 8'(elem >> shamt);
    end

endmodule

// File: rtl/result_serializer.sv
// Snapshots the product on load and streams the active NxN elements
// row-major to uart_tx. Ports: clk_i, rst_ni, load_i, matrix_size_i,
// result_i, tx (master link), busy_o, done_o.
module result_serializer
    import matmul_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [3:0]           matrix_size_i,
    input  logic [RESULT_W-1:0]  result_i,
    result_serializer_if.master  tx,
    output logic                 busy_o,
    output logic                 done_o
);

    state_t                state_q, state_d;
    logic [3:0]            row_q, row_d;
    logic [3:0]            col_q, col_d;
    logic [BYTE_IDX_W-1:0] byte_q, byte_d;
    logic [3:0]            n_q, n_d;
    logic [RESULT_W-1:0]   snap_q, snap_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [7:0]            sel_byte;
    logic                  elem_end;
    logic                  last_byte;

    result_byte_sel u_sel (
        .snap_i (snap_q),
        .row_i  (row_q),
        .col_i  (col_q),
        .byte_i (byte_q),
        .byte_o (sel_byte)
    );

    assign elem_end  = (byte_q == BYTE_IDX_W'(BYTES_PER_ELEM - 1));
    assign last_byte = elem_end
                     && (col_q == n_q - 4'd1)
                     && (row_q == n_q - 4'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            byte_q     <= '0;
            n_q        <= '0;
            snap_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            byte_q     <= byte_d;
            n_q        <= n_d;
            snap_q     <= snap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_i)
                    state_d = (matrix_size_i == 4'd0) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                if (!tx.tx_busy) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx.tx_busy) state_d = S_WAIT_FREE;
            end
            S_WAIT_FREE: begin
                if (!tx.tx_busy)
                    state_d = last_byte ? S_FINISH : S_ISSUE;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        byte_d     = byte_q;
        n_d        = n_q;
        snap_d     = snap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_i && matrix_size_i != 4'd0) begin
                    snap_d = result_i;
                    n_d    = (matrix_size_i > 4'(MAX_N))
                           ? 4'(MAX_N) : matrix_size_i;
                    row_d  = '0;
                    col_d  = '0;
                    byte_d = '0;
                end
            end
            S_ISSUE: begin
                if (!tx.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = sel_byte;
                end
            end
            S_WAIT_FREE: begin
                if (!tx.tx_busy && !last_byte) begin
                    if (!elem_end) begin
                        byte_d = byte_q + 1'b1;
                    end else begin
                        byte_d = '0;
                        if (col_q == n_q - 4'd1) begin
                            col_d = '0;
                            row_d = row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign tx.tx_start = tx_start_q;
    assign tx.tx_data  = tx_data_q;
    assign busy_o      = (state_q == S_ISSUE)
                      || (state_q == S_WAIT_ACK)
                      || (state_q == S_WAIT_FREE);
    assign done_o      = (state_q == S_FINISH);

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: uart model, byte scoreboard, directed tests.
// Expected bytes come from the element/row-major rules applied to result.
module tb_result_serializer;
    import matmul_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                load = 1'b0;
    logic [3:0]          matrix_size = '0;
    logic [RESULT_W-1:0] res = '0;
    logic                busy;
    logic                done;
    logic                force_busy = 1'b0;
    int                  ucnt;

    int       checks = 0;
    int       errors = 0;
    int       byte_cnt = 0;
    int       done_cnt = 0;
    bit       have_last = 0;
    logic [7:0] last_data;
    logic [7:0] exp_q[$];

    result_serializer_if txif();

    result_serializer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .load_i        (load),
        .matrix_size_i (matrix_size),
        .result_i      (res),
        .tx            (txif.master),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // uart model: busy from the cycle after start, for 10 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ucnt <= 0;
        else if (txif.tx_start) ucnt <= 10;
        else if (ucnt != 0) ucnt <= ucnt - 1;
    end
    assign txif.tx_busy = (ucnt != 0) || force_busy;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic build(input logic [RESULT_W-1:0] r, input int sz);
        int n;
        logic [15:0] e;
        n = (sz > MAX_N) ? MAX_N : sz;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                e = r[(i*MAX_N+j)*ELEM_W +: ELEM_W];
                exp_q.push_back(e[15:8]);
                exp_q.push_back(e[7:0]);
            end
    endtask

    task automatic set_elem(input int r, input int c, input logic [15:0] v);
        res[(r*MAX_N+c)*ELEM_W +: ELEM_W] = v;
    endtask

    // call at a negedge; returns at the next negedge
    task automatic pulse_load(input int sz, input bit model);
        if (model) build(res, sz);
        load = 1'b1;
        matrix_size = 4'(sz);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("done_seen", done_cnt - d0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            have_last = 0;
        end else begin
            if (txif.tx_start) begin
                byte_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte actual=%02h required=none",
                             txif.tx_data);
                end else begin
                    check("byte", txif.tx_data, exp_q.pop_front());
                end
                last_data = txif.tx_data;
                have_last = 1;
            end else if (have_last) begin
                check("tx_data_hold", txif.tx_data, last_data);
            end
            if (done) begin
                done_cnt++;
                check("queue_empty_at_done", exp_q.size(), 0);
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        int base;
        int d0;
        int k;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_start", txif.tx_start, 0);
        check("rst_tx_data", txif.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // N=2 basic stream with literal pins on the model
        set_elem(0, 0, 16'h1234);
        set_elem(0, 1, 16'h0005);
        set_elem(1, 0, 16'hABCD);
        set_elem(1, 1, 16'h00FF);
        build(res, 2);
        check("model_n2_size", exp_q.size(), 8);
        check("model_n2_b0", exp_q[0], 8'h12);
        check("model_n2_b1", exp_q[1], 8'h34);
        check("model_n2_b4", exp_q[4], 8'hAB);
        check("model_n2_b7", exp_q[7], 8'hFF);
        exp_q.delete();
        base = byte_cnt;
        pulse_load(2, 1);
        #1;
        check("n2_no_start_cycle1", txif.tx_start, 0);
        check("n2_busy_cycle1", busy, 1);
        @(negedge clk);
        #1;
        check("n2_start_cycle2", txif.tx_start, 1);
        check("n2_first_byte", txif.tx_data, 8'h12);
        wait_done(400);
        check("n2_bytes", byte_cnt - base, 8);
        repeat (2) @(negedge clk);
        check("n2_busy_after", busy, 0);

        // size 0: no bytes, done one cycle after load
        base = byte_cnt;
        d0 = done_cnt;
        pulse_load(0, 1);
        #1;
        check("n0_done", done, 1);
        check("n0_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("n0_bytes", byte_cnt - base, 0);
        check("n0_done_once", done_cnt - d0, 1);
        check("n0_busy_after", busy, 0);

        // N=10, element k = k*257
        for (int i = 0; i < MAX_ELEMS; i++)
            set_elem(i / MAX_N, i % MAX_N, 16'(i * 257));
        build(res, 10);
        check("model_n10_size", exp_q.size(), 200);
        check("model_n10_b20", exp_q[20], 8'd10);
        check("model_n10_b21", exp_q[21], 8'd10);
        check("model_n10_b199", exp_q[199], 8'd99);
        exp_q.delete();
        @(negedge clk);
        base = byte_cnt;
        d0 = done_cnt;
        pulse_load(10, 1);
        wait_done(5000);
        check("n10_bytes", byte_cnt - base, 200);
        repeat (3) @(negedge clk);
        check("n10_done_once", done_cnt - d0, 1);

        // size 12 clamps to 10
        build(res, 12);
        check("model_n12_size", exp_q.size(), 200);
        exp_q.delete();
        base = byte_cnt;
        pulse_load(12, 1);
        wait_done(5000);
        check("n12_bytes", byte_cnt - base, 200);

        // N=3 with a second load and result change mid-stream
        @(negedge clk);
        base = byte_cnt;
        pulse_load(3, 1);
        repeat (30) @(negedge clk);
        for (int i = 0; i < MAX_ELEMS; i++)
            set_elem(i / MAX_N, i % MAX_N, 16'hDEAD);
        pulse_load(2, 0);
        repeat (40) @(negedge clk);
        pulse_load(10, 0);
        wait_done(2000);
        check("n3_ignore_bytes", byte_cnt - base, 18);

        // reset after the 5th byte's tx_start, then restart
        for (int i = 0; i < MAX_ELEMS; i++)
            set_elem(i / MAX_N, i % MAX_N, 16'(16'h0101 * i + 16'h3000));
        @(negedge clk);
        base = byte_cnt;
        d0 = done_cnt;
        pulse_load(3, 1);
        k = 0;
        while (byte_cnt - base < 5 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("rst_mid_reached", byte_cnt - base, 5);
        check("rst_mid_start_hi", txif.tx_start, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_start", txif.tx_start, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_data", txif.tx_data, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_no_done", done_cnt - d0, 0);
        set_elem(0, 0, 16'h7E42);
        base = byte_cnt;
        pulse_load(3, 1);
        @(negedge clk);
        #1;
        check("restart_first", txif.tx_data, 8'h7E);
        wait_done(2000);
        check("restart_bytes", byte_cnt - base, 18);

        // tx_busy high before and across load
        @(negedge clk);
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        base = byte_cnt;
        pulse_load(1, 1);
        repeat (2) @(negedge clk);
        #1;
        check("held_no_start", txif.tx_start, 0);
        check("held_busy", busy, 1);
        force_busy = 1'b0;
        @(negedge clk);
        #1;
        check("held_start_after_fall", txif.tx_start, 1);
        check("held_first_byte", txif.tx_data, 8'h7E);
        wait_done(400);
        check("held_bytes", byte_cnt - base, 2);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
